// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: default widths and FSM state encodings.
// Contents: DEF_ADDR_SIZE, DEF_SLOT_SIZE, ST_* 2-bit encodings, state_e enum built on them.
// Imported by the interface, the top and the starvation counter.
package data_memory_arb_pkg;

    localparam int DEF_ADDR_SIZE = 5;
    localparam int DEF_SLOT_SIZE = 32;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DUMP_RD   = 2'd1;
    localparam logic [1:0] ST_DUMP_HOLD = 2'd2;
    localparam logic [1:0] ST_DUMP_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_DUMP_RD   = ST_DUMP_RD,
        S_DUMP_HOLD = ST_DUMP_HOLD,
        S_DUMP_DONE = ST_DUMP_DONE
    } state_e;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of every arbiter signal except clock/reset; names follow the arbiter's point of view.
// Ports: pipeline side (i_pipe_*, o_pipe_*), debug side (i_dbg_*, o_dbg_*), dump stream (*_dump_*),
// memory side (o_mem_*, i_mem_data), o_busy. Modport slave = arbiter, master = its environment.
interface data_memory_arbiter_if
    import data_memory_arb_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int SLOT_SIZE = DEF_SLOT_SIZE
);
    logic                 i_pipe_req;
    logic                 i_pipe_wr_rd;
    logic [ADDR_SIZE-1:0] i_pipe_addr;
    logic [SLOT_SIZE-1:0] i_pipe_data;
    logic                 o_pipe_gnt;
    logic [SLOT_SIZE-1:0] o_pipe_data;

    logic                 i_dbg_req;
    logic                 i_dbg_wr_rd;
    logic [ADDR_SIZE-1:0] i_dbg_addr;
    logic [SLOT_SIZE-1:0] i_dbg_data;
    logic                 o_dbg_gnt;
    logic [SLOT_SIZE-1:0] o_dbg_data;
    logic                 o_dbg_valid;

    logic                 i_dump_start;
    logic [ADDR_SIZE-1:0] o_dump_addr;
    logic [SLOT_SIZE-1:0] o_dump_data;
    logic                 o_dump_valid;
    logic                 i_dump_ready;
    logic                 o_dump_done;
    logic                 o_busy;

    logic                 o_mem_wr_rd;
    logic [ADDR_SIZE-1:0] o_mem_addr;
    logic [SLOT_SIZE-1:0] o_mem_data;
    logic [SLOT_SIZE-1:0] i_mem_data;

    modport slave (
        input  i_pipe_req, i_pipe_wr_rd, i_pipe_addr, i_pipe_data,
        output o_pipe_gnt, o_pipe_data,
        input  i_dbg_req, i_dbg_wr_rd, i_dbg_addr, i_dbg_data,
        output o_dbg_gnt, o_dbg_data, o_dbg_valid,
        input  i_dump_start, i_dump_ready,
        output o_dump_addr, o_dump_data, o_dump_valid, o_dump_done, o_busy,
        output o_mem_wr_rd, o_mem_addr, o_mem_data,
        input  i_mem_data
    );

    modport master (
        output i_pipe_req, i_pipe_wr_rd, i_pipe_addr, i_pipe_data,
        input  o_pipe_gnt, o_pipe_data,
        output i_dbg_req, i_dbg_wr_rd, i_dbg_addr, i_dbg_data,
        input  o_dbg_gnt, o_dbg_data, o_dbg_valid,
        output i_dump_start, i_dump_ready,
        input  o_dump_addr, o_dump_data, o_dump_valid, o_dump_done, o_busy,
        input  o_mem_wr_rd, o_mem_addr, o_mem_data,
        output i_mem_data
    );

endinterface

// File: rtl/data_memory_arbiter_starve_counter.sv
// Starvation guard: counts consecutive cycles a debug/dump access is pending but blocked.
// Ports: i_clk, i_reset (sync, active-low), i_pending, i_blocked, o_force_slot (count reached limit).
// Counter saturates at STARVE_LIMIT and clears whenever the access is served or nothing is pending.
module arb_starve_counter
    import data_memory_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pending,
    input  logic i_blocked,
    output logic o_force_slot
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset || !i_pending || !i_blocked) begin
            r_cnt <= '0;
        end else if (r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_force_slot = (r_cnt == LIMIT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the data_memory port between the MEM stage (fixed priority, zero-latency grant) and the
// debug unit (single reads/writes plus a full-memory dump streamed over valid/ready).
// Ports: i_clk, i_reset (sync, active-low), bus (data_memory_arbiter_if.slave).
// Optional macro DATA_MEMORY_ARB_STARVE_GUARD_EN: after STARVE_LIMIT blocked cycles one slot is taken from the pipeline.
module data_memory_arbiter
    import data_memory_arb_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int SLOT_SIZE = DEF_SLOT_SIZE
`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
    , parameter int STARVE_LIMIT = 16
`endif
)(
    input  logic               i_clk,
    input  logic               i_reset,
    data_memory_arbiter_if.slave bus
);
    state_e               r_state;
    logic [ADDR_SIZE-1:0] r_cnt;
    logic [SLOT_SIZE-1:0] r_dbg_data;
    logic                 r_dbg_valid;
    logic [SLOT_SIZE-1:0] r_dump_data;
    logic [ADDR_SIZE-1:0] r_dump_addr;
    logic                 r_dump_valid;

    logic                 w_force;
    logic                 w_slot;
    logic                 w_want;
    logic                 w_pipe_gnt;
    logic                 w_dbg_acc;
    logic                 w_dump_acc;
    logic                 w_mem_wr_rd;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [SLOT_SIZE-1:0] w_mem_data;

    // Debug side wants the port: a pending single access (a same-cycle dump start takes precedence
    // and does not touch memory) or a dump word waiting to be read.
    assign w_want = ((r_state == S_IDLE) && !bus.i_dump_start && bus.i_dbg_req) ||
                    (r_state == S_DUMP_RD);

    // The debug side owns this cycle when the pipeline is idle or the starvation guard fires.
    assign w_slot     = !bus.i_pipe_req || w_force;
    assign w_pipe_gnt = bus.i_pipe_req && !(w_force && w_want);

    assign w_dbg_acc  = i_reset && (r_state == S_IDLE) && !bus.i_dump_start &&
                        bus.i_dbg_req && w_slot;
    assign w_dump_acc = i_reset && (r_state == S_DUMP_RD) && w_slot;

`ifdef DATA_MEMORY_ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_pending    (w_want),
        .i_blocked    (!w_slot),
        .o_force_slot (w_force)
    );
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_mem_wr_rd = 1'b0;
        w_mem_addr  = '0;
        w_mem_data  = '0;
        if (w_pipe_gnt) begin
            w_mem_wr_rd = bus.i_pipe_wr_rd;
            w_mem_addr  = bus.i_pipe_addr;
            w_mem_data  = bus.i_pipe_data;
        end else if (w_dbg_acc) begin
            w_mem_wr_rd = bus.i_dbg_wr_rd;
            w_mem_addr  = bus.i_dbg_addr;
            w_mem_data  = bus.i_dbg_data;
        end else if (w_dump_acc) begin
            w_mem_addr  = r_cnt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_dbg_data   <= '0;
            r_dbg_valid  <= 1'b0;
            r_dump_data  <= '0;
            r_dump_addr  <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            r_dbg_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_dump_start) begin
                        r_cnt   <= '0;
                        r_state <= S_DUMP_RD;
                    end else if (w_dbg_acc && !bus.i_dbg_wr_rd) begin
                        r_dbg_data  <= bus.i_mem_data;
                        r_dbg_valid <= 1'b1;
                    end
                end
                S_DUMP_RD: begin
                    if (w_dump_acc) begin
                        r_dump_data  <= bus.i_mem_data;
                        r_dump_addr  <= r_cnt;
                        r_dump_valid <= 1'b1;
                        r_state      <= S_DUMP_HOLD;
                    end
                end
                S_DUMP_HOLD: begin
                    if (bus.i_dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_cnt == '1) begin
                            r_state <= S_DUMP_DONE;
                        end else begin
                            r_cnt   <= r_cnt + ADDR_SIZE'(1);
                            r_state <= S_DUMP_RD;
                        end
                    end
                end
                S_DUMP_DONE: r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_pipe_gnt   = w_pipe_gnt;
    assign bus.o_pipe_data  = bus.i_mem_data;
    assign bus.o_dbg_gnt    = w_dbg_acc;
    assign bus.o_dbg_data   = r_dbg_data;
    assign bus.o_dbg_valid  = r_dbg_valid;
    assign bus.o_dump_addr  = r_dump_addr;
    assign bus.o_dump_data  = r_dump_data;
    assign bus.o_dump_valid = r_dump_valid;
    assign bus.o_dump_done  = (r_state == S_DUMP_DONE);
    assign bus.o_busy       = (r_state != S_IDLE);
    // No memory write may reach data_memory while reset is asserted.
    assign bus.o_mem_wr_rd  = w_mem_wr_rd && i_reset;
    assign bus.o_mem_addr   = w_mem_addr;
    assign bus.o_mem_data   = w_mem_data;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Shares the single port of data_memory between the MIPS MEM stage (the pipeline) and the debug unit.
- Pipeline has fixed priority with a zero-latency grant.
- The debug unit issues single-word reads and writes.
- The debug unit can also request a full-memory dump, streamed out word by word over a valid/ready handshake.
- Sits between the MEM stage, the debug/UART controller and data_memory.

Parameters:
ADDR_SIZE, 5, data memory address width; depth = 2**ADDR_SIZE
SLOT_SIZE, 32, data word width
STARVE_LIMIT, 16, consecutive blocked cycles before a forced debug slot (optional feature only)

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_reset  in  1  synchronous, active-low reset
i_pipe_req  in  1  pipeline access request this cycle
i_pipe_wr_rd  in  1  1 = write, 0 = read
i_pipe_addr  in  ADDR_SIZE  pipeline address
i_pipe_data  in  SLOT_SIZE  pipeline write data
o_pipe_gnt  out  1  pipeline owns the port this cycle (combinational)
o_pipe_data  out  SLOT_SIZE  i_mem_data passthrough (combinational)
i_dbg_req  in  1  debug single access request (level)
i_dbg_wr_rd  in  1  1 = write, 0 = read
i_dbg_addr  in  ADDR_SIZE  debug address
i_dbg_data  in  SLOT_SIZE  debug write data
o_dbg_gnt  out  1  one-cycle pulse: debug access performed this cycle
o_dbg_data  out  SLOT_SIZE  registered read data
o_dbg_valid  out  1  one-cycle pulse, the cycle after a granted read
i_dump_start  in  1  start full dump (pulse)
o_dump_addr  out  ADDR_SIZE  address of o_dump_data
o_dump_data  out  SLOT_SIZE  dumped word
o_dump_valid  out  1  dump word valid
i_dump_ready  in  1  consumer accepts dump word
o_dump_done  out  1  one-cycle pulse after the last word is accepted
o_busy  out  1  FSM not IDLE
o_mem_wr_rd  out  1  to data_memory i_wr_rd
o_mem_addr  out  ADDR_SIZE  to data_memory i_addr
o_mem_data  out  SLOT_SIZE  to data_memory i_data
i_mem_data  in  SLOT_SIZE  from data_memory o_data (combinational read)

Behaviour:
- Memory timing: read is combinational; write commits on the rising edge while o_mem_wr_rd = 1.
- Port mux:
  - i_pipe_req = 1: o_pipe_gnt = 1 and o_mem_* = i_pipe_*.
  - Else: o_mem_* come from the FSM.
  - Else, with the FSM not accessing: wr_rd = 0, addr = 0, data = 0.
- While i_reset = 0: o_mem_wr_rd is forced to 0, so no write occurs.
- Reset values: FSM = IDLE; address counter = 0; o_dbg_data = 0; o_dump_data = 0; o_dump_addr = 0; all valid/gnt/done/busy outputs = 0. Reset mid-dump or mid-access aborts it, with no done pulse.
- FSM states: IDLE, DUMP_RD, DUMP_HOLD, DUMP_DONE.
- IDLE:
  - i_dump_start = 1 → clear counter, go to DUMP_RD. Dump start wins over a simultaneous i_dbg_req; the debug request stays pending.
  - Else if i_dbg_req = 1 and i_pipe_req = 0 → access this cycle and pulse o_dbg_gnt.
    - Read: o_dbg_data <= i_mem_data, and o_dbg_valid pulses the next cycle.
    - Write: the word commits on this edge.
  - i_dbg_req still high after the gnt is treated as a new request, so back-to-back accesses are allowed.
- DUMP_RD: in the first cycle with i_pipe_req = 0, read the counter address, latch o_dump_data and o_dump_addr, set o_dump_valid, go to DUMP_HOLD. A blocked cycle means wait.
- DUMP_HOLD: o_dump_valid stays high with data stable until i_dump_ready = 1.
  - On accept, clear valid.
  - If counter == 2**ADDR_SIZE-1, go to DUMP_DONE.
  - Else counter + 1, go to DUMP_RD.
- DUMP_DONE: o_dump_done = 1 for one cycle, then IDLE.
- During a dump: i_dbg_req gets no grant, and i_dump_start is ignored.
- Counter: ADDR_SIZE bits, no wrap is observed since the dump ends at the top address.
- o_busy = 1 whenever state ≠ IDLE.
- Minimum dump time: 2 cycles per word plus 1 done cycle.

Optional Feature:
DATA_MEMORY_ARB_STARVE_GUARD_EN.
- Defined: a counter increments each cycle that a debug or dump access is pending and blocked by i_pipe_req. When it reaches STARVE_LIMIT:
  - The next cycle is forced to the debug side, with o_pipe_gnt = 0 even though i_pipe_req = 1.
  - The pipeline must stall that cycle.
  - The counter clears on any debug/dump access or when nothing is pending.
- Undefined: the pipeline has absolute priority; o_pipe_gnt == i_pipe_req always.

Decomposition:
- Package data_memory_arb_pkg holds:
  - state encodings ST_IDLE, ST_DUMP_RD, ST_DUMP_HOLD, ST_DUMP_DONE (2-bit localparams);
  - default widths.
- One sub-module, arb_starve_counter: pending/blocked inputs, force_slot output, parameter STARVE_LIMIT. It is instantiated only under the macro.

Test Plan:
- Reset held low for 3 cycles with i_dbg_req = 1 and write → all outputs 0, no memory write; release → gnt on the first cycle with i_pipe_req = 0.
- Debug writes 0xDEADBEEF to address 3, then reads address 3 → o_dbg_valid one cycle after gnt, o_dbg_data = 0xDEADBEEF.
- i_pipe_req = 1 for 10 cycles while i_dbg_req = 1 → no o_dbg_gnt until the first cycle with pipe idle; the pipeline write to address 7 = 0x12345678 commits.
- Preload address k = k*0x11, then dump with i_dump_ready toggling randomly → 32 words, address 0..31 in order, data k*0x11, o_dump_done single pulse, o_busy low after.
- i_dump_start and i_dbg_req in the same cycle → dump runs first, debug gnt only after o_dump_done.
- Macro defined, STARVE_LIMIT = 4, i_pipe_req stuck high with i_dbg_req = 1 → o_pipe_gnt = 0 with o_dbg_gnt = 1 on the cycle after 4 blocked cycles.
